// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo
//   Store-and-forward receive frame FIFO sitting on the MAC rx_axis output.
//   The MAC stream cannot be back-pressured, so every byte is written
//   speculatively at wr_cur. A clean tlast (tuser=0) publishes the frame by
//   moving wr_com forward. A bad frame, or one that runs out of space, is
//   thrown away by rewinding wr_cur to wr_com. Only committed bytes are ever
//   read out, through a single output register on the AXI-Stream master.
//
// Ports
//   clk_i, rst_ni    rx clock, asynchronous active-low reset
//   s_axis_*         MAC byte stream (no tready); tuser qualifies tlast
//   m_axis_*         committed frames out, back-pressurable
//   stat_good_o      one-cycle pulse: frame committed
//   stat_bad_o       one-cycle pulse: frame dropped because tuser=1
//   stat_ovf_o       one-cycle pulse: frame dropped because the buffer filled
//   fill_o           bytes held in storage (committed + in-progress)
module eth_rx_frame_fifo #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              stat_good_o,
    output logic              stat_bad_o,
    output logic              stat_ovf_o,
    output logic [ADDR_W:0]   fill_o
);

    localparam logic [ADDR_W:0] PTR_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

    typedef enum logic {ACCEPT, DROP} state_t;

    state_t state, state_nxt;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_cur, wr_com, rd_ptr;
    logic [ADDR_W:0] wr_cur_nxt, wr_com_nxt, rd_ptr_nxt;

    logic [8:0] mem [DEPTH];   // {last, data}

    logic we;
    logic good_nxt, bad_nxt, ovf_nxt;
    logic full, empty, rd_load;

    // Full uses the pre-update rd_ptr: a read in the same cycle frees no space.
    assign full  = (wr_cur - rd_ptr) == PTR_DEPTH;
    assign empty = (wr_com == rd_ptr);

    // ---------------- write FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ACCEPT;
        else         state <= state_nxt;
    end

    // ---------------- write FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (s_axis_tvalid) begin
            case (state)
                ACCEPT:  if (full && !s_axis_tlast) state_nxt = DROP;
                DROP:    if (s_axis_tlast)          state_nxt = ACCEPT;
                default: state_nxt = ACCEPT;
            endcase
        end
    end

    // ---------------- write FSM: outputs ----------------
    // Every drop path rewinds wr_cur to wr_com, so the partial frame simply
    // vanishes and its space gets reused by the next frame.
    always_comb begin
        we         = 1'b0;
        wr_cur_nxt = wr_cur;
        wr_com_nxt = wr_com;
        good_nxt   = 1'b0;
        bad_nxt    = 1'b0;
        ovf_nxt    = 1'b0;
        if (s_axis_tvalid && state == ACCEPT) begin
            if (full) begin
                wr_cur_nxt = wr_com;
                ovf_nxt    = 1'b1;
            end else if (!s_axis_tlast) begin
                we         = 1'b1;
                wr_cur_nxt = wr_cur + PTR_ONE;
            end else if (!s_axis_tuser) begin
                we         = 1'b1;
                wr_cur_nxt = wr_cur + PTR_ONE;
                wr_com_nxt = wr_cur + PTR_ONE;
                good_nxt   = 1'b1;
            end else begin
                wr_cur_nxt = wr_com;
                bad_nxt    = 1'b1;
            end
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (we) mem[wr_cur[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // ---------------- read side ----------------
    // Refill the output register whenever it is empty or being consumed.
    assign rd_load    = (!m_axis_tvalid || m_axis_tready) && !empty;
    assign rd_ptr_nxt = rd_load ? rd_ptr + PTR_ONE : rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_cur        <= '0;
            wr_com        <= '0;
            rd_ptr        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            stat_good_o   <= 1'b0;
            stat_bad_o    <= 1'b0;
            stat_ovf_o    <= 1'b0;
            fill_o        <= '0;
        end else begin
            wr_cur      <= wr_cur_nxt;
            wr_com      <= wr_com_nxt;
            rd_ptr      <= rd_ptr_nxt;
            stat_good_o <= good_nxt;
            stat_bad_o  <= bad_nxt;
            stat_ovf_o  <= ovf_nxt;
            fill_o      <= wr_cur_nxt - rd_ptr_nxt;
            if (rd_load) begin
                m_axis_tdata  <= mem[rd_ptr[ADDR_W-1:0]][7:0];
                m_axis_tlast  <= mem[rd_ptr[ADDR_W-1:0]][8];
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Bench for eth_rx_frame_fifo. The driver feeds byte frames and runs a
// reference model made of byte counters and queues: bytes committed but not
// yet handed out, bytes of the frame in progress, and one output slot. Good
// frames are pushed into exp_q when committed. The monitor, on the falling
// edge, pops exp_q on every handshake and also checks tvalid, the stat pulses
// and fill_o against the model, plus the AXIS hold rule.
//
// The output register holds one byte outside the DEPTH-byte storage. So when
// a committed frame is waiting with tready low, the following frame gets one
// extra byte before it overflows. The model accounts for this and no fixed
// byte index is hard-coded.
module tb_eth_rx_frame_fifo;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tuser;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic          stat_good_o, stat_bad_o, stat_ovf_o;
    logic [AW:0]   fill_o;

    eth_rx_frame_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .stat_good_o(stat_good_o), .stat_bad_o(stat_bad_o),
        .stat_ovf_o(stat_ovf_o), .fill_o(fill_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_com, m_prog;      // committed-unread bytes, in-progress bytes
    bit          m_ov, m_drop;       // output slot occupied, discarding rest of frame
    logic [8:0]  cur_q[$];
    logic [8:0]  exp_q[$];
    bit          e_good, e_bad, e_ovf, e_valid;
    int          e_fill;
    int          rmode;              // 0: tready low, 1: high, 2: random
    int          n_good, n_bad, n_ovf;

    task automatic model_clear();
        m_com = 0; m_prog = 0; m_ov = 0; m_drop = 0;
        cur_q.delete(); exp_q.delete();
        e_good = 0; e_bad = 0; e_ovf = 0; e_valid = 0; e_fill = 0;
    endtask

    // One clock: drive inputs, advance the model, cross the edge.
    task automatic step(input bit v, input bit l, input bit u, input logic [7:0] d);
        bit rdy, full, ng, nb, no;
        case (rmode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(1, 0));
        endcase
        s_axis_tvalid = v; s_axis_tlast = l; s_axis_tuser = u; s_axis_tdata = d;
        m_axis_tready = rdy;

        full = (m_com + m_prog) == DEPTH;
        if (!m_ov || rdy) begin
            if (m_com > 0) begin m_com--; m_ov = 1; end
            else m_ov = 0;
        end
        ng = 0; nb = 0; no = 0;
        if (v) begin
            if (m_drop) begin
                if (l) m_drop = 0;
            end else if (full) begin
                m_prog = 0; cur_q.delete(); no = 1;
                if (!l) m_drop = 1;
            end else if (!l) begin
                cur_q.push_back({1'b0, d}); m_prog++;
            end else if (!u) begin
                cur_q.push_back({1'b1, d});
                foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                m_com += m_prog + 1; m_prog = 0; cur_q.delete(); ng = 1;
            end else begin
                m_prog = 0; cur_q.delete(); nb = 1;
            end
        end
        @(posedge clk_i);
        e_good = ng; e_bad = nb; e_ovf = no; e_valid = m_ov; e_fill = m_com + m_prog;
        #1;
    endtask

    task automatic send_frame(input int len, input bit bad_f, input int cut, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            if (cut != 0 && i == cut) return;
            while (gap_pct != 0 && $urandom_range(99, 0) < gap_pct) step(0, 0, 0, 8'h00);
            step(1, i == len - 1, (i == len - 1) && bad_f, 8'($urandom));
        end
        step(0, 0, 0, 8'h00);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        rmode = 1;
        while ((exp_q.size() != 0 || m_ov) && n < 10000) begin
            step(0, 0, 0, 8'h00);
            n++;
        end
        step(0, 0, 0, 8'h00);
        chk({nm, "_drained"}, exp_q.size(), 0);
        chk({nm, "_tvalid_idle"}, m_axis_tvalid, 0);
    endtask

    // ---------------- monitor ----------------
    bit          prev_hold;
    logic [7:0]  prev_data;
    logic        prev_last;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_hold = 0;
        end else begin
            logic [8:0] e;
            if (prev_hold) begin
                chk("axis_hold_valid", m_axis_tvalid, 1);
                chk("axis_hold_data", m_axis_tdata, prev_data);
                chk("axis_hold_last", m_axis_tlast, prev_last);
            end
            chk("tvalid", m_axis_tvalid, e_valid);
            chk("stat_good", stat_good_o, e_good);
            chk("stat_bad", stat_bad_o, e_bad);
            chk("stat_ovf", stat_ovf_o, e_ovf);
            chk("fill", fill_o, e_fill);
            chk("fill_le_depth", fill_o <= DEPTH, 1);
            n_good += int'(stat_good_o);
            n_bad  += int'(stat_bad_o);
            n_ovf  += int'(stat_ovf_o);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", m_axis_tdata, e[7:0]);
                    chk("out_last", m_axis_tlast, e[8]);
                end
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int g0, b0, o0;
        rmode = 1; n_good = 0; n_bad = 0; n_ovf = 0;
        model_clear();
        rst_ni = 0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
        s_axis_tdata = 0; m_axis_tready = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_fill", fill_o, 0);
        chk("rst_stats", {stat_good_o, stat_bad_o, stat_ovf_o}, 0);
        rst_ni = 1;
        step(0, 0, 0, 8'h00);

        // 1: single 64B good frame, explicit latency check
        g0 = n_good;
        for (int i = 0; i < 64; i++) step(1, i == 63, 0, 8'(i + 8'h40));
        chk("t1_tvalid_edge_k", m_axis_tvalid, 0);
        step(0, 0, 0, 8'h00);
        chk("t1_tvalid_edge_k1", m_axis_tvalid, 1);
        drain("t1");
        chk("t1_good_cnt", n_good - g0, 1);

        // 2: bad 64B then good 60B
        g0 = n_good; b0 = n_bad;
        send_frame(64, 1, 0, 0);
        send_frame(60, 0, 0, 0);
        drain("t2");
        chk("t2_good_cnt", n_good - g0, 1);
        chk("t2_bad_cnt", n_bad - b0, 1);
        chk("t2_fill_zero", fill_o, 0);

        // 3: tready low, 4000B commits, 200B overflows and is dropped
        g0 = n_good; o0 = n_ovf;
        rmode = 0;
        send_frame(4000, 0, 0, 0);
        send_frame(200, 0, 0, 0);
        chk("t3_good_cnt", n_good - g0, 1);
        chk("t3_ovf_cnt", n_ovf - o0, 1);
        drain("t3");

        // 4: DEPTH-byte frame fits exactly, DEPTH+1 overflows
        g0 = n_good; o0 = n_ovf;
        rmode = 0;
        for (int i = 0; i < DEPTH; i++) step(1, i == DEPTH - 1, 0, 8'($urandom));
        chk("t4_fill_full", fill_o, DEPTH);
        step(0, 0, 0, 8'h00);
        drain("t4a");
        rmode = 0;
        send_frame(DEPTH + 1, 0, 0, 0);
        chk("t4_good_cnt", n_good - g0, 1);
        chk("t4_ovf_cnt", n_ovf - o0, 1);
        drain("t4b");

        // 5: random frames, random tready
        rmode = 2;
        for (int f = 0; f < 24; f++) begin
            send_frame($urandom_range(1518, 64), $urandom_range(9, 0) == 0, 0, 5);
            repeat ($urandom_range(800, 0)) step(0, 0, 0, 8'h00);
        end
        drain("t5");

        // 6: reset while a frame streams out and another streams in
        rmode = 1;
        send_frame(200, 0, 0, 0);
        send_frame(300, 0, 100, 0);
        rst_ni = 0;
        #1;
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_fill", fill_o, 0);
        model_clear();
        s_axis_tvalid = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1;
        g0 = n_good;
        send_frame(80, 0, 0, 0);
        drain("t6");
        chk("t6_good_cnt", n_good - g0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
